hart_mem_arbiter: RTL and testbench

HART_MEM_ARBITER -- requirements
Module: hart_mem_arbiter

---
 rtl/arvi_mem_pkg.sv | 27 ++
 rtl/arb_rr2.sv | 26 ++
 rtl/hart_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_hart_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_mem_pkg.sv
// Shared types and constants for the hart memory arbiter.
//   state_e : arbiter FSM states
//   gnt_e   : which hart port owns the memory (instruction fetch or data)
//   BE_ALL  : full-word byte enable used for fetches and data reads
//   TMR_W   : width of the bus timeout down-counter

`ifndef XLEN
`define XLEN 32
`endif

package arvi_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_e;

   localparam logic [3:0] BE_ALL = 4'hF;
   localparam int         TMR_W  = 16;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker, purely combinational.
//   req_i[0] : instruction-fetch request
//   req_i[1] : data request
//   last_i   : port granted most recently
//   gnt_o    : one-hot grant (bit 0 fetch, bit 1 data), 0 when nobody asks

module arb_rr2
   import arvi_mem_pkg::*;
(
   input  logic [1:0] req_i,
   input  gnt_e       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         // contention: hand the memory to whoever did not have it last
         2'b11:   gnt_o = (last_i == GNT_D) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Arbitrates a hart's instruction-fetch and data ports onto one
// single-ported memory, one transaction at a time, with a bus timeout.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no transaction; sample requests, pick a port, latch command
//   BUSY  | o_MEM_req high from latched command; wait ack or timeout
//   DONE  | one-cycle ready pulse to the granted port (+ o_bus_err)
//
// Ports
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_IC_DataReq, i_IM_Addr        fetch request / address
//   o_IM_Instr, o_IC_MemReady      fetched word / completion pulse
//   i_DM_req, i_DM_we, i_DM_addr,  data request, write enable, address,
//   i_DM_wdata, i_DM_be            write data, byte enables
//   o_DM_rdata, o_DM_ready         read data / completion pulse
//   o_MEM_req, o_MEM_we, o_MEM_addr,
//   o_MEM_wdata, o_MEM_be          shared memory command
//   i_MEM_rdata, i_MEM_ack         memory response
//   o_bus_err                      timeout abort, coincident with ready

module hart_mem_arbiter
   import arvi_mem_pkg::*;
#(
   parameter int XLEN    = `XLEN,
   parameter int TIMEOUT = 256
)(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_IC_DataReq,
   input  logic [XLEN-1:0] i_IM_Addr,
   output logic [XLEN-1:0] o_IM_Instr,
   output logic            o_IC_MemReady,
   input  logic            i_DM_req,
   input  logic            i_DM_we,
   input  logic [XLEN-1:0] i_DM_addr,
   input  logic [XLEN-1:0] i_DM_wdata,
   input  logic [3:0]      i_DM_be,
   output logic [XLEN-1:0] o_DM_rdata,
   output logic            o_DM_ready,
   output logic            o_MEM_req,
   output logic            o_MEM_we,
   output logic [XLEN-1:0] o_MEM_addr,
   output logic [XLEN-1:0] o_MEM_wdata,
   output logic [3:0]      o_MEM_be,
   input  logic [XLEN-1:0] i_MEM_rdata,
   input  logic            i_MEM_ack,
   output logic            o_bus_err
);

   // The timeout runs as a down-counter: loaded on entry to BUSY and
   // aborting at zero, which gives exactly TIMEOUT BUSY cycles.
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   gnt_e              last_q,  last_d;
   gnt_e              gnt_q,   gnt_d;
   logic [XLEN-1:0]   addr_q,  addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              we_q,    we_d;
   logic              err_q,   err_d;
   logic [3:0]        be_q,    be_d;
   logic [TMR_W-1:0]  tmr_q,   tmr_d;

   logic [1:0]        req;
   logic [1:0]        grant;

   assign req = {i_DM_req, i_IC_DataReq};

   arb_rr2 u_arb (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (grant)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      we_d    = we_q;
      err_d   = err_q;
      be_d    = be_q;
      tmr_d   = tmr_q;

      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               state_d = BUSY;
               tmr_d   = TMR_LOAD;
               err_d   = 1'b0;
               rdata_d = '0;
               if (grant == 2'b10) begin
                  gnt_d   = GNT_D;
                  last_d  = GNT_D;
                  addr_d  = i_DM_addr;
                  we_d    = i_DM_we;
                  wdata_d = i_DM_we ? i_DM_wdata : '0;
                  be_d    = i_DM_we ? i_DM_be : BE_ALL;
               end else begin
                  gnt_d   = GNT_I;
                  last_d  = GNT_I;
                  addr_d  = i_IM_Addr;
                  we_d    = 1'b0;
                  wdata_d = '0;
                  be_d    = BE_ALL;
               end
            end
         end

         BUSY: begin
            // ack has priority over a timeout landing in the same cycle
            if (i_MEM_ack) begin
               rdata_d = i_MEM_rdata;
               err_d   = 1'b0;
               state_d = DONE;
            end else if (tmr_q == '0) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         last_q  <= GNT_I;
         gnt_q   <= GNT_I;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         be_q    <= 4'h0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         err_q   <= err_d;
         be_q    <= be_d;
         tmr_q   <= tmr_d;
      end
   end

   // Moore outputs; everything not belonging to the current state is 0.
   always_comb begin
      o_MEM_req     = 1'b0;
      o_MEM_we      = 1'b0;
      o_MEM_addr    = '0;
      o_MEM_wdata   = '0;
      o_MEM_be      = 4'h0;
      o_IC_MemReady = 1'b0;
      o_IM_Instr    = '0;
      o_DM_ready    = 1'b0;
      o_DM_rdata    = '0;
      o_bus_err     = 1'b0;

      if (state_q == BUSY) begin
         o_MEM_req   = 1'b1;
         o_MEM_we    = we_q;
         o_MEM_addr  = addr_q;
         o_MEM_wdata = wdata_q;
         o_MEM_be    = be_q;
      end

      if (state_q == DONE) begin
         o_bus_err = err_q;
         if (gnt_q == GNT_I) begin
            o_IC_MemReady = 1'b1;
            o_IM_Instr    = rdata_q;
         end else begin
            o_DM_ready = 1'b1;
            o_DM_rdata = we_q ? '0 : rdata_q;
         end
      end
   end

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Scoreboard bench for hart_mem_arbiter (TIMEOUT=8).
// Stimulus pushes the expected memory command and the expected completion;
// a negedge bus process plays the memory, checks commands and pops
// completions whenever a ready pulse appears.

module tb_hart_mem_arbiter;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        i_rst;
   logic        i_IC_DataReq;
   logic [31:0] i_IM_Addr;
   logic [31:0] o_IM_Instr;
   logic        o_IC_MemReady;
   logic        i_DM_req, i_DM_we;
   logic [31:0] i_DM_addr, i_DM_wdata;
   logic [3:0]  i_DM_be;
   logic [31:0] o_DM_rdata;
   logic        o_DM_ready;
   logic        o_MEM_req, o_MEM_we;
   logic [31:0] o_MEM_addr, o_MEM_wdata;
   logic [3:0]  o_MEM_be;
   logic [31:0] i_MEM_rdata;
   logic        i_MEM_ack;
   logic        o_bus_err;

   hart_mem_arbiter #(.XLEN(32), .TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_IC_DataReq(i_IC_DataReq), .i_IM_Addr(i_IM_Addr),
      .o_IM_Instr(o_IM_Instr), .o_IC_MemReady(o_IC_MemReady),
      .i_DM_req(i_DM_req), .i_DM_we(i_DM_we), .i_DM_addr(i_DM_addr),
      .i_DM_wdata(i_DM_wdata), .i_DM_be(i_DM_be),
      .o_DM_rdata(o_DM_rdata), .o_DM_ready(o_DM_ready),
      .o_MEM_req(o_MEM_req), .o_MEM_we(o_MEM_we), .o_MEM_addr(o_MEM_addr),
      .o_MEM_wdata(o_MEM_wdata), .o_MEM_be(o_MEM_be),
      .i_MEM_rdata(i_MEM_rdata), .i_MEM_ack(i_MEM_ack),
      .o_bus_err(o_bus_err)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          delay;   // BUSY cycle in which to ack; 0 = never
      logic [31:0] rdata;
   } mem_t;

   typedef struct {
      bit          port_d;
      logic [31:0] rdata;
      bit          err;
      int          busy_len;
   } sb_t;

   mem_t mem_q[$];
   sb_t  sb_q[$];

   int n_checks = 0;
   int n_errs   = 0;
   bit stray_en = 1'b0;
   int busy_cnt = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string msg);
      n_checks++;
      n_errs++;
      $display("FAIL %s", msg);
   endtask

   // ---------------- memory side + completion monitor ----------------
   initial begin
      mem_t cur;
      sb_t  e;
      bit   rdy;
      cur = '{default: '0};
      i_MEM_ack   = 1'b0;
      i_MEM_rdata = '0;
      forever begin
         @(negedge clk);
         rdy = o_IC_MemReady | o_DM_ready;
         if (rdy) begin
            chk("ready_exclusive", {159'd0, o_IC_MemReady & o_DM_ready}, 160'd0);
            if (sb_q.size() == 0) begin
               fail("unexpected_ready");
            end else begin
               e = sb_q.pop_front();
               chk("ready_port", {159'd0, o_DM_ready}, {159'd0, e.port_d});
               chk("ready_rdata", e.port_d ? o_DM_rdata : o_IM_Instr, e.rdata);
               chk("other_port_data", e.port_d ? o_IM_Instr : o_DM_rdata, 160'd0);
               chk("bus_err", {159'd0, o_bus_err}, {159'd0, e.err});
               chk("busy_len", busy_cnt, e.busy_len);
               chk("mem_req_in_done", {159'd0, o_MEM_req}, 160'd0);
            end
         end else if (o_bus_err) begin
            fail("bus_err_without_ready");
         end
         if (busy_cnt > 0 && !o_MEM_req && !rdy && !i_rst)
            fail("busy_ended_without_ready");

         if (o_MEM_req) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
               if (mem_q.size() == 0) begin
                  fail("unexpected_mem_req");
                  cur = '{default: '0};
               end else begin
                  cur = mem_q.pop_front();
               end
               chk("mem_addr", o_MEM_addr, cur.addr);
               chk("mem_we", {159'd0, o_MEM_we}, {159'd0, cur.we});
               chk("mem_be", {156'd0, o_MEM_be}, {156'd0, cur.be});
               if (cur.we) chk("mem_wdata", o_MEM_wdata, cur.wdata);
            end else begin
               chk("mem_stable", {o_MEM_addr, o_MEM_we, o_MEM_be},
                   {cur.addr, cur.we, cur.be});
               if (cur.we) chk("mem_wdata_stable", o_MEM_wdata, cur.wdata);
            end
            if (busy_cnt == cur.delay) begin
               i_MEM_ack   = 1'b1;
               i_MEM_rdata = cur.rdata;
            end else begin
               i_MEM_ack   = 1'b0;
               i_MEM_rdata = $urandom;
            end
         end else begin
            busy_cnt    = 0;
            i_MEM_ack   = stray_en;
            i_MEM_rdata = $urandom;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_txn(input bit d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] rdata, input int delay);
      mem_t m;
      sb_t  s;
      bit   err;
      err = (delay == 0 || delay > TMO);
      m.addr = addr; m.we = we; m.wdata = wdata;
      m.be = we ? be : 4'hF;
      m.delay = delay; m.rdata = rdata;
      s.port_d = d; s.err = err;
      s.busy_len = err ? TMO : delay;
      s.rdata = (err || we) ? 32'h0 : rdata;
      mem_q.push_back(m);
      sb_q.push_back(s);
   endtask

   task automatic drive_i(input logic [31:0] addr);
      i_IC_DataReq = 1'b1;
      i_IM_Addr    = addr;
   endtask

   task automatic drive_d(input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
      i_DM_req   = 1'b1;
      i_DM_we    = we;
      i_DM_addr  = addr;
      i_DM_wdata = wdata;
      i_DM_be    = be;
   endtask

   task automatic wait_dones(input int n, input bit hold);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         if (o_DM_ready) begin
            got++;
            if (!hold) i_DM_req = 1'b0;
         end
         if (o_IC_MemReady) begin
            got++;
            if (!hold) i_IC_DataReq = 1'b0;
         end
      end
      if (got < n) begin
         n_checks++;
         n_errs++;
         $display("FAIL wait_ready_timeout: got %0d completions, required %0d", got, n);
      end
      i_DM_req     = 1'b0;
      i_IC_DataReq = 1'b0;
   endtask

   task automatic chk_outs_zero(input string name);
      chk(name, {3'd0, o_IM_Instr, o_IC_MemReady, o_DM_rdata, o_DM_ready, o_MEM_req,
                 o_MEM_we, o_MEM_addr, o_MEM_wdata, o_MEM_be, o_bus_err}, 160'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      i_rst = 1'b1;
      i_IC_DataReq = 1'b0; i_IM_Addr = '0;
      i_DM_req = 1'b0; i_DM_we = 1'b0; i_DM_addr = '0; i_DM_wdata = '0; i_DM_be = '0;

      // requests raised during reset must not start anything
      @(posedge clk); #1;
      drive_i(32'h0000_0AAA);
      drive_d(1'b0, 32'h0000_BBBB, 32'h0, 4'h0);
      @(posedge clk); #1;
      chk_outs_zero("reset_outs_a");
      @(posedge clk); #1;
      chk_outs_zero("reset_outs_b");
      i_IC_DataReq = 1'b0;
      i_DM_req     = 1'b0;
      i_rst        = 1'b0;
      @(posedge clk); #1;
      chk_outs_zero("post_reset_outs");

      // simultaneous after reset: data first, then fetch
      push_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h1111_1111, 2);
      push_txn(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h2222_2222, 1);
      drive_i(32'h0000_0200);
      drive_d(1'b0, 32'h0000_1000, 32'hBAD0_BAD0, 4'h5);
      wait_dones(2, 1'b0);

      // fetch only, ack in first BUSY cycle
      push_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0013, 1);
      drive_i(32'h0000_0100);
      wait_dones(1, 1'b0);

      // data read, garbage wdata/be must not leak to memory
      push_txn(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'hCAFE_F00D, 3);
      drive_d(1'b0, 32'h0000_1004, 32'h1234_5678, 4'h5);
      wait_dones(1, 1'b0);

      // stray acks outside BUSY from here on
      stray_en = 1'b1;

      // data write, second consecutive data grant
      push_txn(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 32'hFFFF_FFFF, 4);
      drive_d(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011);
      wait_dones(1, 1'b0);

      // timeout, then ack exactly at the timeout cycle, then fetch timeout
      push_txn(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 32'h7777_7777, 0);
      drive_d(1'b0, 32'h0000_4000, 32'h0, 4'h0);
      wait_dones(1, 1'b0);
      push_txn(1'b1, 1'b0, 32'h0000_4004, 32'h0, 4'h0, 32'h55AA_55AA, TMO);
      drive_d(1'b0, 32'h0000_4004, 32'h0, 4'h0);
      wait_dones(1, 1'b0);
      push_txn(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 32'h9999_9999, TMO + 1);
      drive_i(32'h0000_0500);
      wait_dones(1, 1'b0);

      // reset in the 2nd BUSY cycle of a data read: no completion expected
      begin
         mem_t m;
         m.addr = 32'h0000_3000; m.we = 1'b0; m.wdata = '0; m.be = 4'hF;
         m.delay = 0; m.rdata = '0;
         mem_q.push_back(m);
      end
      drive_d(1'b0, 32'h0000_3000, 32'h0, 4'h0);
      @(posedge clk);
      @(posedge clk); #1;
      chk("busy_before_reset", {159'd0, o_MEM_req}, {159'd0, 1'b1});
      i_rst    = 1'b1;
      i_DM_req = 1'b0;
      @(posedge clk); #1;
      chk("rst_mem_req_drop", {159'd0, o_MEM_req}, 160'd0);
      chk_outs_zero("rst_mid_busy_outs");
      @(posedge clk); #1;
      i_rst = 1'b0;
      push_txn(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'h3333_3333, 2);
      push_txn(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h4444_4444, 5);
      drive_i(32'h0000_0300);
      drive_d(1'b0, 32'h0000_3000, 32'h0, 4'h0);
      wait_dones(2, 1'b0);

      // both held for six transactions: D,I,D,I,D,I
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0)
            push_txn(1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 32'h6000_0000 + k, 1 + k % 3);
         else
            push_txn(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'h0, 32'h0600_0000 + k, 1 + k % 3);
      end
      drive_i(32'h0000_0600);
      drive_d(1'b0, 32'h0000_6000, 32'h0, 4'h0);
      wait_dones(6, 1'b1);

      stray_en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb_q.size(), 0);
      chk("mem_queue_drained", mem_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
